// File: rtl/roce_tx_pkg.sv
// roce_tx_pkg: shared types and defaults for the TX completion tracker
package roce_tx_pkg;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_DEPTH = 64;
  localparam int DEF_TAG_W = $clog2(DEF_DEPTH);
  typedef enum logic [1:0] {
    ST_FREE,
    ST_PENDING,
    ST_DONE
  } entry_state_e;
  typedef struct packed {
    logic is_read;
    logic [DEF_DATA_WIDTH-1:0] data;
  } ret_t;
endpackage

// File: rtl/completion_tracker_cmp_data_ram.sv
// cmp_data_ram: completion data store, written by tag and read asynchronously at head
module cmp_data_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH = 64,
  parameter int TAG_W = $clog2(DEPTH)
) (
  input  logic clk,
  input  logic we_i,
  input  logic [TAG_W-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [TAG_W-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end
  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/completion_tracker.sv
// completion_tracker: in-order tag allocator and reorder buffer for memory completions
module completion_tracker
  import roce_tx_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int TAG_W = $clog2(DEPTH)
) (
  input  logic clk,
  input  logic rst,
  input  logic alloc_valid,
  input  logic alloc_is_read,
  output logic alloc_ready,
  output logic [TAG_W-1:0] alloc_tag,
  input  logic cmp_valid,
  input  logic [TAG_W-1:0] cmp_tag,
  input  logic [DATA_WIDTH-1:0] cmp_data,
  output logic ret_valid,
  output logic ret_is_read,
  output logic [DATA_WIDTH-1:0] ret_data,
  input  logic ret_ready,
  output logic [TAG_W:0] count,
  output logic err_spurious
);
  logic [TAG_W:0] head_q, head_d, tail_q, tail_d;
  entry_state_e st_q [DEPTH];
  entry_state_e st_d [DEPTH];
  logic [DEPTH-1:0] rd_q, rd_d;
  logic ret_valid_q, ret_valid_d, ret_is_read_q, ret_is_read_d, err_q;
  logic [DATA_WIDTH-1:0] ret_data_q, ret_data_d, head_data;
  logic [TAG_W-1:0] head_idx, tail_idx;
  logic alloc_fire, cmp_ok, load;

  assign head_idx = head_q[TAG_W-1:0];
  assign tail_idx = tail_q[TAG_W-1:0];
  assign count = tail_q - head_q;
  assign alloc_ready = count != (TAG_W+1)'(DEPTH);
  assign alloc_tag = tail_idx;
  assign alloc_fire = alloc_valid & alloc_ready;
  assign cmp_ok = cmp_valid & (st_q[cmp_tag] == ST_PENDING);
  // Alloc (FREE tail), completion (PENDING) and load (DONE head) never hit the same entry
  assign load = (st_q[head_idx] == ST_DONE) & (~ret_valid_q | ret_ready);
  assign ret_valid = ret_valid_q;
  assign ret_is_read = ret_is_read_q;
  assign ret_data = ret_data_q;
  assign err_spurious = err_q;

  cmp_data_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH(DEPTH),
    .TAG_W(TAG_W)
  ) u_ram (
    .clk(clk),
    .we_i(cmp_ok),
    .waddr_i(cmp_tag),
    .wdata_i(rd_q[cmp_tag] ? cmp_data : '0),
    .raddr_i(head_idx),
    .rdata_o(head_data)
  );

  always_comb begin
    st_d = st_q;
    rd_d = rd_q;
    head_d = head_q;
    tail_d = tail_q;
    ret_valid_d = load | (ret_valid_q & ~ret_ready);
    ret_is_read_d = load ? rd_q[head_idx] : ret_is_read_q;
    ret_data_d = load ? head_data : ret_data_q;
    if (alloc_fire) begin
      st_d[tail_idx] = ST_PENDING;
      rd_d[tail_idx] = alloc_is_read;
      tail_d = tail_q + 1'b1;
    end
    if (cmp_ok) st_d[cmp_tag] = ST_DONE;
    if (load) begin
      st_d[head_idx] = ST_FREE;
      head_d = head_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      st_q <= '{default: ST_FREE};
      rd_q <= '0;
      head_q <= '0;
      tail_q <= '0;
      ret_valid_q <= 1'b0;
      ret_is_read_q <= 1'b0;
      ret_data_q <= '0;
      err_q <= 1'b0;
    end else begin
      st_q <= st_d;
      rd_q <= rd_d;
      head_q <= head_d;
      tail_q <= tail_d;
      ret_valid_q <= ret_valid_d;
      ret_is_read_q <= ret_is_read_d;
      ret_data_q <= ret_data_d;
      err_q <= cmp_valid & ~cmp_ok;
    end
  end
endmodule

// File: tb/tb_completion_tracker.sv
// tb_completion_tracker: table, directed and randomized checks against a queue-based model
module tb_completion_tracker;
  localparam int DW = 32;
  localparam int DEPTH = 64;
  localparam int TW = 6;
  localparam int M_FREE = 0;
  localparam int M_PEND = 1;
  localparam int M_DONE = 2;

  logic clk = 0, rst = 0;
  logic alloc_valid = 0, alloc_is_read = 0, cmp_valid = 0, ret_ready = 0;
  logic [TW-1:0] cmp_tag = '0;
  logic [DW-1:0] cmp_data = '0;
  logic alloc_ready, ret_valid, ret_is_read, err_spurious;
  logic [TW-1:0] alloc_tag;
  logic [DW-1:0] ret_data;
  logic [TW:0] count;
  int tests = 0, fails = 0;

  int q_tag[$];
  int mstate[DEPTH];
  bit mrd[DEPTH];
  logic [DW-1:0] mdata[DEPTH];
  bit m_rv, m_rrd, m_err;
  logic [DW-1:0] m_rdata;
  int m_tail;

  typedef struct {
    bit av; bit ard; bit cv; logic [TW-1:0] ct; logic [DW-1:0] cd; bit rr;
    int e_tag; bit e_rv; logic [DW-1:0] e_data; int e_cnt; bit e_err;
  } vec_t;
  vec_t tbl[10];

  completion_tracker dut (
    .clk(clk), .rst(rst),
    .alloc_valid(alloc_valid), .alloc_is_read(alloc_is_read),
    .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
    .cmp_valid(cmp_valid), .cmp_tag(cmp_tag), .cmp_data(cmp_data),
    .ret_valid(ret_valid), .ret_is_read(ret_is_read), .ret_data(ret_data),
    .ret_ready(ret_ready), .count(count), .err_spurious(err_spurious)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q_tag.delete();
    foreach (mstate[i]) mstate[i] = M_FREE;
    m_rv = 0; m_rrd = 0; m_rdata = '0; m_err = 0; m_tail = 0;
  endtask

  // Advance the model by one edge using the inputs present at that edge
  task automatic model_edge();
    bit a_fire, c_ok, ld;
    int t;
    if (!rst) begin
      model_reset();
      return;
    end
    a_fire = alloc_valid && q_tag.size() != DEPTH;
    c_ok = cmp_valid && mstate[cmp_tag] == M_PEND;
    ld = q_tag.size() > 0 && mstate[q_tag[0]] == M_DONE && (!m_rv || ret_ready);
    m_err = cmp_valid && !c_ok;
    if (ld) begin
      t = q_tag.pop_front();
      m_rv = 1; m_rrd = mrd[t]; m_rdata = mdata[t]; mstate[t] = M_FREE;
    end else if (ret_ready) m_rv = 0;
    if (c_ok) begin
      mstate[cmp_tag] = M_DONE;
      mdata[cmp_tag] = mrd[cmp_tag] ? cmp_data : '0;
    end
    if (a_fire) begin
      t = m_tail % DEPTH;
      mstate[t] = M_PEND; mrd[t] = alloc_is_read;
      q_tag.push_back(t);
      m_tail++;
    end
  endtask

  task automatic check_model();
    chk("m_ret_valid", ret_valid, m_rv);
    chk("m_ret_is_read", ret_is_read, m_rrd);
    chk("m_ret_data", ret_data, m_rdata);
    chk("m_count", count, q_tag.size());
    chk("m_alloc_ready", alloc_ready, q_tag.size() != DEPTH);
    chk("m_alloc_tag", alloc_tag, m_tail % DEPTH);
    chk("m_err", err_spurious, m_err);
  endtask

  task automatic cycle();
    check_model();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive(bit av, bit ard, bit cv, int ct, logic [DW-1:0] cd, bit rr);
    alloc_valid = av; alloc_is_read = ard; cmp_valid = cv;
    cmp_tag = TW'(ct); cmp_data = cd; ret_ready = rr;
  endtask

  task automatic do_reset();
    rst = 0;
    drive(0, 0, 0, 0, '0, 0);
    @(posedge clk);
    model_reset();
    #1;
    rst = 1;
  endtask

  initial begin
    int t4tags[4];
    int t6tags[11];
    int seq, rseq, old_tag;
    bit wrapped;
    bit sb_rd[200];
    logic [DW-1:0] sb_data[200];
    int seq_of_tag[DEPTH];

    do_reset();
    chk("rst_ret_valid", ret_valid, 0);
    chk("rst_count", count, 0);
    chk("rst_alloc_ready", alloc_ready, 1);
    chk("rst_alloc_tag", alloc_tag, 0);
    chk("rst_err", err_spurious, 0);
    chk("rst_ret_data", ret_data, 0);

    // Three reads completed in reverse; retire in issue order
    tbl[0] = '{1, 1, 0, 0, 0, 1, 0, 0, 0, 1, 0};
    tbl[1] = '{1, 1, 0, 0, 0, 1, 1, 0, 0, 2, 0};
    tbl[2] = '{1, 1, 0, 0, 0, 1, 2, 0, 0, 3, 0};
    tbl[3] = '{0, 0, 1, 2, 32'hCCCC_0003, 1, -1, 0, 0, 3, 0};
    tbl[4] = '{0, 0, 1, 1, 32'hBBBB_0002, 1, -1, 0, 0, 3, 0};
    tbl[5] = '{0, 0, 1, 0, 32'hAAAA_0001, 1, -1, 0, 0, 3, 0};
    tbl[6] = '{0, 0, 0, 0, 0, 1, -1, 1, 32'hAAAA_0001, 2, 0};
    tbl[7] = '{0, 0, 0, 0, 0, 1, -1, 1, 32'hBBBB_0002, 1, 0};
    tbl[8] = '{0, 0, 0, 0, 0, 1, -1, 1, 32'hCCCC_0003, 0, 0};
    tbl[9] = '{0, 0, 0, 0, 0, 1, -1, 0, 0, 0, 0};
    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].av, tbl[i].ard, tbl[i].cv, tbl[i].ct, tbl[i].cd, tbl[i].rr);
      if (tbl[i].av) chk("t1_alloc_tag", alloc_tag, tbl[i].e_tag);
      cycle();
      chk("t1_ret_valid", ret_valid, tbl[i].e_rv);
      if (tbl[i].e_rv) chk("t1_ret_data", ret_data, tbl[i].e_data);
      chk("t1_count", count, tbl[i].e_cnt);
      chk("t1_err", err_spurious, tbl[i].e_err);
    end

    // Fill all 64 entries with writes, then free one
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      drive(1, 0, 0, 0, '0, 1);
      cycle();
    end
    chk("t2_full_ready", alloc_ready, 0);
    chk("t2_full_count", count, 64);
    cycle();
    chk("t2_65th_count", count, 64);
    chk("t2_65th_tag", alloc_tag, 0);
    drive(0, 0, 1, 0, 32'hDEAD_BEEF, 1);
    cycle();
    drive(0, 0, 0, 0, '0, 1);
    chk("t2_before_load_ready", alloc_ready, 0);
    cycle();
    chk("t2_load_count", count, 63);
    chk("t2_load_ready", alloc_ready, 1);
    chk("t2_load_valid", ret_valid, 1);
    chk("t2_write_data", ret_data, 0);
    chk("t2_write_type", ret_is_read, 0);
    for (int t = 1; t < DEPTH; t++) begin
      drive(0, 0, 1, t, 32'h1234_0000 + t, 1);
      cycle();
    end
    drive(0, 0, 0, 0, '0, 1);
    for (int k = 0; k < 300 && !(count == 0 && !ret_valid); k++) cycle();
    chk("t2_drained", (count == 0 && !ret_valid), 1);

    // Spurious completions: FREE tag, then a repeat on an already-DONE tag
    drive(0, 0, 1, 5, 32'h5555_5555, 1);
    cycle();
    drive(0, 0, 0, 0, '0, 0);
    chk("t3_free_err", err_spurious, 1);
    chk("t3_free_noret", ret_valid, 0);
    cycle();
    chk("t3_err_clear", err_spurious, 0);
    drive(1, 1, 0, 0, '0, 0);
    chk("t3_tag", alloc_tag, 0);
    cycle();
    drive(0, 0, 1, 0, 32'h3333_0001, 0);
    cycle();
    drive(0, 0, 1, 0, 32'h3333_0002, 0);
    cycle();
    drive(0, 0, 0, 0, '0, 0);
    chk("t3_dup_err", err_spurious, 1);
    chk("t3_dup_valid", ret_valid, 1);
    chk("t3_dup_data", ret_data, 32'h3333_0001);
    cycle();
    chk("t3_dup_err_clear", err_spurious, 0);
    chk("t3_count", count, 0);
    drive(0, 0, 0, 0, '0, 1);
    cycle();
    chk("t3_consumed", ret_valid, 0);

    // Back-pressure with four DONE entries
    for (int k = 0; k < 4; k++) begin
      drive(1, 1, 0, 0, '0, 0);
      t4tags[k] = alloc_tag;
      cycle();
    end
    for (int k = 3; k >= 0; k--) begin
      drive(0, 0, 1, t4tags[k], 32'h4000_0000 + k, 0);
      cycle();
    end
    drive(0, 0, 0, 0, '0, 0);
    cycle();
    for (int k = 0; k < 10; k++) begin
      chk("t4_hold_valid", ret_valid, 1);
      chk("t4_hold_data", ret_data, 32'h4000_0000);
      chk("t4_hold_count", count, 3);
      cycle();
    end
    ret_ready = 1;
    for (int k = 0; k < 4; k++) begin
      chk("t4_rel_valid", ret_valid, 1);
      chk("t4_rel_data", ret_data, 32'h4000_0000 + k);
      cycle();
    end
    chk("t4_rel_empty", ret_valid, 0);

    // Randomized: 200 requests, random completion order, independent scoreboard
    do_reset();
    seq = 0; rseq = 0; wrapped = 0;
    for (int cyc = 0; cyc < 6000 && rseq < 200; cyc++) begin
      int pend[$];
      pend.delete();
      foreach (mstate[i]) if (mstate[i] == M_PEND) pend.push_back(i);
      drive(seq < 200 && $urandom_range(0, 3) != 0, $urandom_range(0, 1), 0, 0, $urandom,
            $urandom_range(0, 3) != 0);
      if ($urandom_range(0, 19) == 0) begin
        cmp_valid = 1; cmp_tag = TW'($urandom_range(0, DEPTH - 1));
      end else if (pend.size() > 0 && $urandom_range(0, 2) != 0) begin
        cmp_valid = 1; cmp_tag = TW'(pend[$urandom_range(0, pend.size() - 1)]);
      end
      if (cmp_valid && mstate[cmp_tag] == M_PEND)
        sb_data[seq_of_tag[cmp_tag]] = sb_rd[seq_of_tag[cmp_tag]] ? cmp_data : '0;
      if (alloc_valid && alloc_ready) begin
        chk("t5_alloc_tag", alloc_tag, seq % DEPTH);
        if (alloc_tag == 0 && seq > 0) wrapped = 1;
        seq_of_tag[seq % DEPTH] = seq;
        sb_rd[seq] = alloc_is_read;
        sb_data[seq] = '0;
        seq++;
      end
      if (ret_valid && ret_ready && rseq < 200) begin
        chk("t5_sb_data", ret_data, sb_data[rseq]);
        chk("t5_sb_type", ret_is_read, sb_rd[rseq]);
        rseq++;
      end
      cycle();
    end
    chk("t5_all_retired", rseq, 200);
    chk("t5_wrapped", wrapped, 1);

    // Reset with work in flight
    do_reset();
    for (int k = 0; k < 11; k++) begin
      drive(1, 1, 0, 0, '0, 0);
      t6tags[k] = alloc_tag;
      cycle();
    end
    drive(0, 0, 1, t6tags[0], 32'h6666_0000, 0);
    cycle();
    drive(0, 0, 0, 0, '0, 0);
    for (int k = 0; k < 5 && !ret_valid; k++) cycle();
    chk("t6_pre_valid", ret_valid, 1);
    chk("t6_pre_count", count, 10);
    old_tag = t6tags[3];
    do_reset();
    chk("t6_rst_valid", ret_valid, 0);
    chk("t6_rst_count", count, 0);
    chk("t6_rst_tag", alloc_tag, 0);
    chk("t6_rst_ready", alloc_ready, 1);
    drive(0, 0, 1, old_tag, 32'h6666_0003, 0);
    cycle();
    drive(0, 0, 0, 0, '0, 0);
    chk("t6_old_err", err_spurious, 1);
    cycle();
    chk("t6_old_noret", ret_valid, 0);
    chk("t6_old_count", count, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
